// File: rtl/clock_gate_mux_inv.sv
//==============================================================================
// Module      : clock_gate_mux_inv
// Description : Glitch-free gated clock with selectable phase (clockIn or its
//               inverse). Two latch-based clock gates, one per phase, feed a
//               2:1 clock mux. A small FSM sequences phase switches so that
//               both gates are closed while the mux select moves.
//
// Ports       : clockIn    - sole clock; FSM runs on the rising edge
//               reset      - asynchronous, active-high reset
//               enable     - functional clock-gate enable
//               te         - test enable, forces both gates open
//               sel        - requested phase (0 = clockIn, 1 = ~clockIn)
//               clockOut   - gated, phase-selected output clock
//               clockGated - phase-0 gated clock (gate-0 latch Q AND clockIn)
//               clockInv   - ungated inverse of clockIn
//               selActive  - phase currently driving clockOut
//               busy       - phase switch in progress
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module clock_gate_mux_inv #(
    parameter int QUIET_CYCLES = 2      // full clockIn cycles both gates stay closed (1..15)
) (
    input  logic clockIn,
    input  logic reset,
    input  logic enable,
    input  logic te,
    input  logic sel,
    output logic clockOut,
    output logic clockGated,
    output logic clockInv,
    output logic selActive,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWAP   = 2'd2,
        ST_RESUME = 2'd3
    } state_t;

    // DRAIN counts down from this value to zero, giving QUIET_CYCLES edges.
    localparam logic [3:0] c_QUIET_LOAD = 4'(QUIET_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_quietCnt;
    logic       r_selActive;
    logic       r_busy;
    logic       r_q0;           // gate-0 latch, transparent while clockIn low
    logic       r_q1;           // gate-1 latch, transparent while clockIn high

    logic       w_run;
    logic       w_en0;
    logic       w_en1;
    logic       w_gated1;

    //--------------------------------------------------------------------------
    // Switch sequencer. selActive only toggles on the SWAP->RESUME edge; by
    // then both latches have been fed a zero enable for at least one full
    // transparent phase, so neither path is driving a high level.
    //--------------------------------------------------------------------------
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_quietCnt  <= 4'd0;
            r_selActive <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (sel != r_selActive) begin
                        r_state    <= ST_DRAIN;
                        r_quietCnt <= c_QUIET_LOAD;
                        r_busy     <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_quietCnt == 4'd0) begin
                        r_state <= ST_SWAP;
                    end else begin
                        r_quietCnt <= r_quietCnt - 4'd1;
                    end
                end
                ST_SWAP: begin
                    r_selActive <= ~r_selActive;
                    r_state     <= ST_RESUME;
                end
                ST_RESUME: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_run = (r_state == ST_RUN);

    // te bypasses the sequencer entirely so scan clocks are never held off.
    assign w_en0 = (enable & w_run & ~r_selActive) | te;
    assign w_en1 = (enable & w_run &  r_selActive) | te;

    //--------------------------------------------------------------------------
    // Clock-gate latches. Each latch is transparent only while its own path
    // output is forced low by the AND gate, so an enable change can never
    // shorten a pulse that is already in flight.
    //--------------------------------------------------------------------------
    always_latch begin
        if (reset) begin
            r_q0 <= 1'b0;
        end else if (!clockIn) begin
            r_q0 <= w_en0;
        end
    end

    always_latch begin
        if (reset) begin
            r_q1 <= 1'b0;
        end else if (clockIn) begin
            r_q1 <= w_en1;
        end
    end

    assign clockInv   = ~clockIn;
    assign clockGated = r_q0 & clockIn;
    assign w_gated1   = r_q1 & clockInv;

    // Select only moves while both gated paths are low, so the mux is safe.
    assign clockOut   = r_selActive ? w_gated1 : clockGated;

    assign selActive  = r_selActive;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_clock_gate_mux_inv.sv
//==============================================================================
// Module      : tb_clock_gate_mux_inv
// Description : Self-checking bench for clock_gate_mux_inv. A reference model
//               tracks, per rising edge, the active phase and whether the
//               sequencer is running, using edge-index arithmetic for switch
//               timing; each clockOut half-phase is predicted from that.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ps/1ps
`default_nettype none

module tb_clock_gate_mux_inv;

    localparam int Q = 2;

    logic clockIn = 1'b0;
    logic reset;
    logic enable;
    logic te;
    logic sel;
    logic clockOut;
    logic clockGated;
    logic clockInv;
    logic selActive;
    logic busy;

    clock_gate_mux_inv #(.QUIET_CYCLES(Q)) dut (
        .clockIn    (clockIn),
        .reset      (reset),
        .enable     (enable),
        .te         (te),
        .sel        (sel),
        .clockOut   (clockOut),
        .clockGated (clockGated),
        .clockInv   (clockInv),
        .selActive  (selActive),
        .busy       (busy)
    );

    always #500 clockIn = ~clockIn;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int   n        = 0;      // rising-edge index
    int   runFrom  = 0;      // first edge index after which the sequencer is back in RUN
    int   toggleAt = -1000;  // edge index on which the active phase flips
    logic mSelPrev = 1'b0;
    logic mRunPrev = 1'b1;
    logic mSel, mRun;

    // Expected and observed values for one clock period
    logic eHi, eLo, eGated, eBusy, eSel;
    logic oHi, oLo, oGatedHi, oGatedLo, oBusy, oSel, oInvHi, oInvLo;

    // Minimum half-period monitor on clockOut
    logic monEn = 1'b0;
    time  lastT = 0;
    always @(clockOut) begin
        if (monEn) begin
            checks++;
            if ($time - lastT < 500) begin
                errors++;
                $display("FAIL min_phase: clockOut phase %0t ps, required >= 500 ps", $time - lastT);
            end
            lastT = $time;
        end
    end

    task automatic mon_on();
        lastT = $time - 1000;
        monEn = 1'b1;
    endtask

    task automatic model_reset();
        runFrom  = n;
        toggleAt = -1000;
        mSelPrev = 1'b0;
        mRunPrev = 1'b1;
    endtask

    // Advance one clockIn period: predict, sample mid-high, apply new inputs
    // mid-high, then sample mid-low.
    task automatic tick(input logic nEn, input logic nSel, input logic nTe);
        logic q0e, q1e;
        @(posedge clockIn);
        q0e = (enable && mRunPrev && !mSelPrev) || te;
        n++;
        if (mRunPrev && (sel != mSelPrev)) begin
            toggleAt = n + Q + 1;
            runFrom  = n + Q + 2;
        end
        mSel   = (n == toggleAt) ? !mSelPrev : mSelPrev;
        mRun   = (n >= runFrom);
        eBusy  = !mRun;
        eSel   = mSel;
        eGated = q0e;
        eHi    = mSel ? 1'b0 : q0e;
        #250;
        oHi = clockOut; oGatedHi = clockGated; oBusy = busy; oSel = selActive; oInvHi = clockInv;
        #50;
        enable = nEn; sel = nSel; te = nTe;
        @(negedge clockIn);
        q1e = (enable && mRun && mSel) || te;
        eLo = mSel ? q1e : 1'b0;
        #250;
        oLo = clockOut; oGatedLo = clockGated; oInvLo = clockInv;
        mRunPrev = mRun;
        mSelPrev = mSel;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; te = 1'b0; sel = 1'b0;
        repeat (2) begin
            @(posedge clockIn); #250;
            checks++; if (clockOut !== 1'b0) begin errors++; $display("FAIL rst_out: got %b exp 0", clockOut); end
            checks++; if (clockGated !== 1'b0) begin errors++; $display("FAIL rst_gated: got %b exp 0", clockGated); end
            checks++; if (selActive !== 1'b0) begin errors++; $display("FAIL rst_sel: got %b exp 0", selActive); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
            checks++; if (clockInv !== 1'b0) begin errors++; $display("FAIL rst_inv: got %b exp 0", clockInv); end
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_track();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++; if (oHi !== eHi) begin errors++; $display("FAIL track_hi n=%0d: got %b exp %b", n, oHi, eHi); end
            checks++; if (oLo !== eLo) begin errors++; $display("FAIL track_lo n=%0d: got %b exp %b", n, oLo, eLo); end
            checks++; if (oGatedHi !== eGated) begin errors++; $display("FAIL track_gated n=%0d: got %b exp %b", n, oGatedHi, eGated); end
            checks++; if (oGatedLo !== 1'b0) begin errors++; $display("FAIL track_gated_lo n=%0d: got %b exp 0", n, oGatedLo); end
            checks++; if ((oInvHi !== 1'b0) || (oInvLo !== 1'b1)) begin errors++; $display("FAIL track_inv n=%0d: got %b%b exp 01", n, oInvHi, oInvLo); end
        end
    endtask

    task automatic test_enable_gate();
        mon_on();
        for (int i = 0; i < 20; i++) begin
            tick((i < 4) ? 1'b0 : ((i < 8) ? 1'b1 : 1'($urandom_range(0, 1))), 1'b0, 1'b0);
            checks++; if (oHi !== eHi) begin errors++; $display("FAIL en_hi n=%0d: got %b exp %b", n, oHi, eHi); end
            checks++; if (oLo !== eLo) begin errors++; $display("FAIL en_lo n=%0d: got %b exp %b", n, oLo, eLo); end
            checks++; if (oGatedHi !== eGated) begin errors++; $display("FAIL en_gated n=%0d: got %b exp %b", n, oGatedHi, eGated); end
        end
    endtask

    task automatic test_switch();
        int busyCnt;
        busyCnt = 0;
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (oBusy === 1'b1) busyCnt++;
            checks++; if (oHi !== eHi) begin errors++; $display("FAIL sw_hi n=%0d: got %b exp %b", n, oHi, eHi); end
            checks++; if (oLo !== eLo) begin errors++; $display("FAIL sw_lo n=%0d: got %b exp %b", n, oLo, eLo); end
            checks++; if (oBusy !== eBusy) begin errors++; $display("FAIL sw_busy n=%0d: got %b exp %b", n, oBusy, eBusy); end
            checks++; if (oSel !== eSel) begin errors++; $display("FAIL sw_sel n=%0d: got %b exp %b", n, oSel, eSel); end
        end
        checks++; if (busyCnt != Q + 2) begin errors++; $display("FAIL sw_busy_len: got %0d edges exp %0d", busyCnt, Q + 2); end
        checks++; if (oSel !== 1'b1) begin errors++; $display("FAIL sw_final_sel: got %b exp 1", oSel); end
    endtask

    task automatic test_back_to_back();
        int swaps;
        logic lastSel;
        swaps = 0;
        lastSel = selActive;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        if (oSel !== lastSel) swaps++;
        lastSel = oSel;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            if (oSel !== lastSel) swaps++;
            lastSel = oSel;
            checks++; if (oHi !== eHi) begin errors++; $display("FAIL b2b_hi n=%0d: got %b exp %b", n, oHi, eHi); end
            checks++; if (oLo !== eLo) begin errors++; $display("FAIL b2b_lo n=%0d: got %b exp %b", n, oLo, eLo); end
            checks++; if (oBusy !== eBusy) begin errors++; $display("FAIL b2b_busy n=%0d: got %b exp %b", n, oBusy, eBusy); end
            checks++; if (oSel !== eSel) begin errors++; $display("FAIL b2b_sel n=%0d: got %b exp %b", n, oSel, eSel); end
        end
        checks++; if (swaps != 2) begin errors++; $display("FAIL b2b_swaps: got %0d exp 2", swaps); end
    endtask

    task automatic test_random();
        logic nEn, nSel;
        for (int i = 0; i < 60; i++) begin
            nEn  = ($urandom_range(0, 3) != 0);
            nSel = ($urandom_range(0, 5) == 0) ? ~sel : sel;
            tick(nEn, nSel, 1'b0);
            checks++; if (oHi !== eHi) begin errors++; $display("FAIL rnd_hi n=%0d: got %b exp %b", n, oHi, eHi); end
            checks++; if (oLo !== eLo) begin errors++; $display("FAIL rnd_lo n=%0d: got %b exp %b", n, oLo, eLo); end
            checks++; if (oBusy !== eBusy) begin errors++; $display("FAIL rnd_busy n=%0d: got %b exp %b", n, oBusy, eBusy); end
            checks++; if (oSel !== eSel) begin errors++; $display("FAIL rnd_sel n=%0d: got %b exp %b", n, oSel, eSel); end
            checks++; if (oGatedHi !== eGated) begin errors++; $display("FAIL rnd_gated n=%0d: got %b exp %b", n, oGatedHi, eGated); end
        end
    endtask

    task automatic test_reset_mid();
        // Make phase 1 active, then start a switch back and reset inside DRAIN.
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        checks++; if (oBusy !== 1'b1 || oSel !== 1'b1) begin errors++; $display("FAIL mid_pre: busy/sel got %b%b exp 11", oBusy, oSel); end
        monEn = 1'b0;
        @(posedge clockIn); #250;
        reset = 1'b1;
        #1;
        checks++; if (clockOut !== 1'b0) begin errors++; $display("FAIL mid_out: got %b exp 0", clockOut); end
        checks++; if (selActive !== 1'b0) begin errors++; $display("FAIL mid_sel: got %b exp 0", selActive); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b exp 0", busy); end
        checks++; if (clockGated !== 1'b0) begin errors++; $display("FAIL mid_gated: got %b exp 0", clockGated); end
        @(posedge clockIn); #250;
        checks++; if (clockOut !== 1'b0 || clockInv !== 1'b0) begin errors++; $display("FAIL mid_hold: out/inv got %b%b exp 00", clockOut, clockInv); end
        sel = 1'b0; enable = 1'b1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            checks++; if (oHi !== eHi) begin errors++; $display("FAIL post_hi n=%0d: got %b exp %b", n, oHi, eHi); end
            checks++; if (oLo !== eLo) begin errors++; $display("FAIL post_lo n=%0d: got %b exp %b", n, oLo, eLo); end
            checks++; if (oSel !== eSel) begin errors++; $display("FAIL post_sel n=%0d: got %b exp %b", n, oSel, eSel); end
        end
    endtask

    task automatic test_scan();
        monEn = 1'b0;
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 14; i++) begin
            tick(1'b0, (i < 4) ? 1'b0 : 1'b1, 1'b1);
            checks++; if (oHi !== eHi) begin errors++; $display("FAIL scan_hi n=%0d: got %b exp %b", n, oHi, eHi); end
            checks++; if (oLo !== eLo) begin errors++; $display("FAIL scan_lo n=%0d: got %b exp %b", n, oLo, eLo); end
            checks++; if (oSel !== eSel) begin errors++; $display("FAIL scan_sel n=%0d: got %b exp %b", n, oSel, eSel); end
        end
        checks++; if (oSel !== 1'b1 || oLo !== 1'b1) begin errors++; $display("FAIL scan_final: sel/lo got %b%b exp 11", oSel, oLo); end
        tick(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_track();
        test_enable_gate();
        test_switch();
        test_back_to_back();
        mon_on();
        test_random();
        test_reset_mid();
        test_scan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
